// File: rtl/series_pkg.sv
// series_pkg: shared state encoding and default sizing for the series job dispatcher.
package series_pkg;
  localparam int XW_DEF = 8;
  localparam int RW_DEF = 16;
  localparam int DEPTH_DEF = 4;
  localparam int TMO_DEF = 64;
  typedef enum logic [2:0] {IDLE, START, WAIT_BUSY, WAIT_DONE, HOLD} state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock operand FIFO; caller never pushes when full nor pops when empty.
module sync_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr, rd;
  logic [AW:0] count;
  assign dout = mem[rd];
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  always_ff @(posedge clk)
    if (push) mem[wr] <= din;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else begin
      if (push) wr <= wr + 1'b1;
      if (pop) rd <= rd + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
endmodule

// File: rtl/series_job_dispatcher.sv
// series_job_dispatcher: queues operands, runs one engine job at a time, returns results in order.
module series_job_dispatcher import series_pkg::*; #(
  parameter int XW = XW_DEF,
  parameter int RW = RW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int TMO = TMO_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [XW-1:0] in_x,
  output logic          in_ready,
  output logic          eng_start,
  output logic [XW-1:0] eng_x,
  input  logic          eng_ready,
  input  logic          eng_busy,
  input  logic [RW-1:0] eng_result,
  output logic          out_valid,
  output logic [RW-1:0] out_r,
  input  logic          out_ready,
  output logic          err
);
  localparam int TW = $clog2(TMO);
  state_t state;
  logic [TW-1:0] timer;
  logic [XW-1:0] head;
  logic push, pop, full, empty, capture, consume;
  assign in_ready = !full;
  assign push = in_valid & !full;
  assign pop = (state == IDLE) & !empty & eng_ready;
  assign consume = out_valid & out_ready;
  // A finished result may land while the previous one is being consumed in the same cycle.
  assign capture = (((state == WAIT_DONE) & eng_ready) | (state == HOLD)) & (!out_valid | out_ready);
  sync_fifo #(.W(XW), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .din(in_x),
    .dout(head),
    .full(full),
    .empty(empty)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      timer <= '0;
      eng_start <= 1'b0;
      eng_x <= '0;
      out_valid <= 1'b0;
      out_r <= '0;
      err <= 1'b0;
    end else begin
      eng_start <= pop;
      if (pop) eng_x <= head;
      if (capture) begin
        out_r <= eng_result;
        out_valid <= 1'b1;
      end else if (consume) out_valid <= 1'b0;
      case (state)
        IDLE: if (pop) state <= START;
        START: state <= WAIT_BUSY;
        WAIT_BUSY:
          if (eng_busy) begin
            state <= WAIT_DONE;
            timer <= '0;
          end else if (timer == TW'(TMO - 1)) begin
            err <= 1'b1;
            state <= IDLE;
            timer <= '0;
          end else timer <= timer + 1'b1;
        WAIT_DONE: if (eng_ready) state <= capture ? IDLE : HOLD;
        HOLD: if (capture) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_series_job_dispatcher.sv
// tb_series_job_dispatcher: directed checks of the dispatcher against a behavioural engine model.
module tb_series_job_dispatcher;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, eng_start, eng_ready, eng_busy, out_valid, out_ready, err;
  logic [7:0] in_x, eng_x, lx;
  logic [15:0] eng_result, out_r;
  logic e_ready, stall, no_busy;
  int busy_len, ecnt, starts, n_checks, n_fail;
  logic [15:0] got_q[$];

  always #5 clk = ~clk;

  series_job_dispatcher dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_x(in_x), .in_ready(in_ready),
    .eng_start(eng_start), .eng_x(eng_x), .eng_ready(eng_ready), .eng_busy(eng_busy),
    .eng_result(eng_result), .out_valid(out_valid), .out_r(out_r), .out_ready(out_ready), .err(err)
  );

  function automatic logic [15:0] f(input logic [7:0] x);
    return (16'(x) << 5) + 16'd4;
  endfunction

  // Engine: on start, busy for busy_len cycles then ready with result; no_busy models a dead engine.
  assign eng_ready = e_ready & !stall;
  always @(posedge clk or posedge rst)
    if (rst) begin
      e_ready <= 1'b1; eng_busy <= 1'b0; eng_result <= '0; ecnt <= 0; lx <= '0;
    end else if (eng_busy) begin
      if (ecnt <= 1) begin eng_busy <= 1'b0; e_ready <= 1'b1; eng_result <= f(lx); end
      ecnt <= ecnt - 1;
    end else if (eng_start && !no_busy) begin
      eng_busy <= 1'b1; e_ready <= 1'b0; ecnt <= busy_len; lx <= eng_x;
    end

  always @(negedge clk) begin
    #1;
    if (out_valid && out_ready) got_q.push_back(out_r);
    if (eng_start) starts++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] x);
    int k = 0;
    in_valid = 1'b1;
    in_x = x;
    while (!in_ready && k < 200) begin @(negedge clk); k++; end
    if (!in_ready) check("push_timeout", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_n(input int n);
    int k = 0;
    while (got_q.size() < n && k < 1000) begin @(negedge clk); k++; end
    check("result_count", 32'(got_q.size()), 32'(n));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_eng_start"}, 32'(eng_start), 32'd0);
    check({tag, "_eng_x"}, 32'(eng_x), 32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_r"}, 32'(out_r), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, s0;
    logic x_ok;
    rst = 1'b1; in_valid = 1'b0; in_x = '0; out_ready = 1'b0;
    stall = 1'b0; no_busy = 1'b0; busy_len = 12;
    n_checks = 0; n_fail = 0; starts = 0;
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;
    @(negedge clk);

    // 1: single job, start two cycles after acceptance
    push(8'h05);
    check("t1_no_start_yet", 32'(eng_start), 32'd0);
    @(negedge clk);
    check("t1_start", 32'(eng_start), 32'd1);
    check("t1_eng_x", 32'(eng_x), 32'h05);
    @(negedge clk);
    check("t1_start_pulse", 32'(eng_start), 32'd0);
    k = 0; x_ok = 1'b1;
    while (!out_valid && k < 100) begin x_ok &= (eng_x == 8'h05); @(negedge clk); k++; end
    check("t1_eng_x_stable", 32'(x_ok), 32'd1);
    check("t1_out_valid", 32'(out_valid), 32'd1);
    check("t1_out_r", 32'(out_r), 32'h00A4);
    check("t1_starts", 32'(starts), 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    check("t1_cleared", 32'(out_valid), 32'd0);
    check("t1_got", 32'(got_q[0]), 32'h00A4);

    // 2: burst of five with engine stalled; fifth waits for space
    busy_len = 3; stall = 1'b1;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    check("t2_full", 32'(in_ready), 32'd0);
    in_valid = 1'b1; in_x = 8'h55;
    @(negedge clk);
    check("t2_held", 32'(in_ready), 32'd0);
    stall = 1'b0;
    push(8'h55);
    wait_n(6);
    check("t2_r0", 32'(got_q[1]), 32'h0224);
    check("t2_r1", 32'(got_q[2]), 32'h0444);
    check("t2_r2", 32'(got_q[3]), 32'h0664);
    check("t2_r3", 32'(got_q[4]), 32'h0884);
    check("t2_r4", 32'(got_q[5]), 32'h0AA4);
    check("t2_starts", 32'(starts), 32'd6);

    // 3 + 6: backpressure parks second job in HOLD, then capture and consume coincide
    out_ready = 1'b0;
    s0 = starts;
    push(8'h01); push(8'h02); push(8'h03);
    repeat (60) @(negedge clk);
    check("t3_starts_held", 32'(starts - s0), 32'd2);
    check("t3_valid", 32'(out_valid), 32'd1);
    check("t3_first", 32'(out_r), 32'h0024);
    out_ready = 1'b1;
    @(negedge clk);
    check("t6_valid_kept", 32'(out_valid), 32'd1);
    check("t6_new_data", 32'(out_r), 32'h0044);
    wait_n(9);
    check("t3_r0", 32'(got_q[6]), 32'h0024);
    check("t3_r1", 32'(got_q[7]), 32'h0044);
    check("t3_r2", 32'(got_q[8]), 32'h0064);
    check("t3_starts", 32'(starts - s0), 32'd3);

    // 4: engine never goes busy -> err after TMO cycles, then recovery
    no_busy = 1'b1;
    push(8'h07);
    k = 0;
    while (!eng_start && k < 50) begin @(negedge clk); k++; end
    check("t4_start", 32'(eng_start), 32'd1);
    repeat (64) @(negedge clk);
    check("t4_err_not_yet", 32'(err), 32'd0);
    @(negedge clk);
    check("t4_err", 32'(err), 32'd1);
    no_busy = 1'b0;
    push(8'h08);
    wait_n(10);
    check("t4_next_job", 32'(got_q[9]), 32'h0104);
    check("t4_err_sticky", 32'(err), 32'd1);

    // 5: reset in the middle of a long job with three operands queued
    busy_len = 40; out_ready = 1'b0;
    push(8'h0A);
    k = 0;
    while (!eng_busy && k < 50) begin @(negedge clk); k++; end
    check("t5_busy", 32'(eng_busy), 32'd1);
    push(8'h0B); push(8'h0C); push(8'h0D);
    rst = 1'b1;
    @(negedge clk);
    check_reset_state("t5_reset");
    rst = 1'b0;
    s0 = starts;
    repeat (10) @(negedge clk);
    check("t5_fifo_flushed", 32'(starts - s0), 32'd0);
    check("t5_no_output", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
